// File: rtl/muxn_scan.sv
// N-to-1 multiplexer with a registered output, selected either manually or by a
// dwell-timed scan sequencer that steps through every channel in turn.
module muxn_scan #(
  parameter int N  = 8,
  parameter int W  = 8,
  parameter int SW = $clog2(N),
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N*W-1:0]  x,
  input  logic [SW-1:0]   sel,
  input  logic            mode,
  input  logic [DW-1:0]   dwell,
  input  logic            en,
  output logic [W-1:0]    y,
  output logic [SW-1:0]   ch,
  output logic            valid,
  output logic            wrap
);

  // One extra bit so N itself is representable when N is a power of two.
  localparam logic [SW:0]   N_EXT   = (SW+1)'(N);
  localparam logic [SW-1:0] LAST_CH = SW'(N-1);

  logic [SW-1:0] ch_q, ch_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  y_q, y_d;
  logic          valid_q, valid_d;
  logic          wrap_q, wrap_d;
  logic [W-1:0]  x_sel;

  always_comb begin
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    if (en) begin
      valid_d = 1'b1;
      if (!mode) begin
        cnt_d = '0;
        if ({1'b0, sel} < N_EXT) begin
          ch_d = sel;
        end
      end else if (cnt_q >= dwell) begin
        // >= rather than == so a dwell lowered below the running count steps at once.
        cnt_d = '0;
        if (ch_q == LAST_CH) begin
          ch_d   = '0;
          wrap_d = 1'b1;
        end else begin
          ch_d = ch_q + SW'(1);
        end
      end else begin
        cnt_d = cnt_q + DW'(1);
      end
    end
  end

  // Data is picked with the next channel index so y and ch always agree.
  always_comb begin
    x_sel = '0;
    for (int k = 0; k < N; k++) begin
      if (ch_d == SW'(k)) begin
        x_sel = x[k*W +: W];
      end
    end
  end

  assign y_d = en ? x_sel : y_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_q    <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign y     = y_q;
  assign ch    = ch_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule
